// File: rtl/display_scanner_if.sv
// Bundle of the write/commit/enable inputs and the registered display outputs
// of the multiplexed 4-digit 7-segment scanner.
interface display_scanner_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       atualiza;
  logic       habilita;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic [3:0] anodo;
  logic       pendente;
  logic       quadro;

  modport master (
    output wr_en, wr_addr, wr_data, atualiza, habilita,
    input  A, B, C, D, anodo, pendente, quadro
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, atualiza, habilita,
    output A, B, C, D, anodo, pendente, quadro
  );
endinterface

// File: rtl/display_scanner.sv
// Double-buffered 4-digit multiplexed display scanner (BLANK/SHOW per digit).
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module display_scanner #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 4
) (
  input logic               clk,
  input logic               rst_n,
  display_scanner_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

  state_t      state_r, state_nxt_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [1:0]  idx_r, idx_nxt_s;

  logic [3:0]  shadow_r [4];
  logic [3:0]  active_r [4];
  logic [3:0]  shadow_nxt_s [4];
  logic [3:0]  active_nxt_s [4];
  logic        pend_r, pend_nxt_s;
  logic        boundary_s;
  logic        commit_s;

  logic [3:0]  digit_r, digit_nxt_s;
  logic [3:0]  anodo_r, anodo_nxt_s;
  logic        quadro_r, quadro_nxt_s;

`ifdef LEADING_ZERO_BLANK_EN
  logic [15:0] active_flat_s;

  // True when digit n (n > 0) and every more significant digit are zero.
  function automatic logic lz_suppress(input logic [15:0] bank, input logic [1:0] n);
    logic [15:0] upper;
    upper = bank >> {n, 2'b00};
    return (n != 2'd0) && (upper == 16'd0);
  endfunction
`endif

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BLANK;
      cnt_r   <= 16'd0;
      idx_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Scan FSM next-state: BLANK then SHOW for each digit, advancing idx after SHOW.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + 16'd1;
    idx_nxt_s   = idx_r;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == BLANK_LAST) begin
          state_nxt_s = ST_SHOW;
          cnt_nxt_s   = 16'd0;
        end else begin
          state_nxt_s = ST_BLANK;
        end
      end
      ST_SHOW: begin
        if (cnt_r == DIV_LAST) begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = 16'd0;
          idx_nxt_s   = idx_r + 2'd1;
        end else begin
          state_nxt_s = ST_SHOW;
        end
      end
      default: begin
        state_nxt_s = ST_BLANK;
        cnt_nxt_s   = 16'd0;
        idx_nxt_s   = 2'd0;
      end
    endcase
  end

  // Bank update: same-cycle write is merged before a boundary commit copies it.
  always_comb begin
    boundary_s = (state_r == ST_SHOW) && (idx_r == 2'd3) && (cnt_r == DIV_LAST);
    commit_s   = boundary_s && pend_r;
    for (int i = 0; i < 4; i++) begin
      if (bus.wr_en && (bus.wr_addr == 2'(i))) begin
        shadow_nxt_s[i] = bus.wr_data;
      end else begin
        shadow_nxt_s[i] = shadow_r[i];
      end
      if (commit_s) begin
        active_nxt_s[i] = shadow_nxt_s[i];
      end else begin
        active_nxt_s[i] = active_r[i];
      end
    end
    if (commit_s) begin
      pend_nxt_s = 1'b0;
    end else if (bus.atualiza) begin
      pend_nxt_s = 1'b1;
    end else begin
      pend_nxt_s = pend_r;
    end
  end

  // Output decode from the upcoming state so the registered outputs align with it.
  always_comb begin
    digit_nxt_s  = active_nxt_s[idx_nxt_s];
    quadro_nxt_s = (state_nxt_s == ST_SHOW) && (idx_nxt_s == 2'd3) && (cnt_nxt_s == DIV_LAST);
`ifdef LEADING_ZERO_BLANK_EN
    active_flat_s = {active_nxt_s[3], active_nxt_s[2], active_nxt_s[1], active_nxt_s[0]};
    if ((state_nxt_s == ST_SHOW) && bus.habilita && !lz_suppress(active_flat_s, idx_nxt_s)) begin
      anodo_nxt_s = ~(4'b0001 << idx_nxt_s);
    end else begin
      anodo_nxt_s = 4'b1111;
    end
`else
    if ((state_nxt_s == ST_SHOW) && bus.habilita) begin
      anodo_nxt_s = ~(4'b0001 << idx_nxt_s);
    end else begin
      anodo_nxt_s = 4'b1111;
    end
`endif
  end

  // Digit banks, commit flag and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        shadow_r[i] <= 4'd0;
        active_r[i] <= 4'd0;
      end
      pend_r   <= 1'b0;
      digit_r  <= 4'd0;
      anodo_r  <= 4'b1111;
      quadro_r <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        shadow_r[i] <= shadow_nxt_s[i];
        active_r[i] <= active_nxt_s[i];
      end
      pend_r   <= pend_nxt_s;
      digit_r  <= digit_nxt_s;
      anodo_r  <= anodo_nxt_s;
      quadro_r <= quadro_nxt_s;
    end
  end

  assign bus.A        = digit_r[3];
  assign bus.B        = digit_r[2];
  assign bus.C        = digit_r[1];
  assign bus.D        = digit_r[0];
  assign bus.anodo    = anodo_r;
  assign bus.pendente = pend_r;
  assign bus.quadro   = quadro_r;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (DIV=4, BLANK=2) against a
// frame-position reference model with random stimulus.
module tb_display_scanner;
  localparam int DIV   = 4;
  localparam int BLANK = 2;
  localparam int DIGIT = DIV + BLANK;
  localparam int FRAME = 4 * DIGIT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_scanner_if bus ();

  display_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // reference model: cycle position since reset plus the two banks
  int         t;
  bit         pend;
  bit         hab;
  logic [3:0] sh [4];
  logic [3:0] ac [4];
  logic [10:0] exp_v;

  function automatic logic [10:0] observed();
    return {bus.anodo, bus.quadro, bus.pendente, bus.A, bus.B, bus.C, bus.D};
  endfunction

  function automatic logic [10:0] expect_out();
    int p;
    int d;
    logic [3:0] an;
    p  = t % FRAME;
    d  = p / DIGIT;
    an = 4'b1111;
    if (((p % DIGIT) >= BLANK) && hab) an = ~(4'b0001 << d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      bit allz;
      allz = 1'b1;
      for (int m = d; m < 4; m++) if (ac[m] != 4'd0) allz = 1'b0;
      if (allz) an = 4'b1111;
    end
`endif
    return {an, (p == FRAME - 1), pend, ac[d]};
  endfunction

  task automatic model_reset();
    t    = 0;
    pend = 1'b0;
    hab  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sh[i] = 4'd0;
      ac[i] = 4'd0;
    end
  endtask

  task automatic idle();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = 2'd0;
    bus.wr_data  = 4'd0;
    bus.atualiza = 1'b0;
  endtask

  // one clock: model applies the rules for the inputs seen at this edge
  task automatic tick();
    bit boundary;
    @(posedge clk);
    boundary = ((t % FRAME) == FRAME - 1);
    if (bus.wr_en) sh[bus.wr_addr] = bus.wr_data;
    if (boundary && pend) begin
      ac   = sh;
      pend = 1'b0;
    end else if (bus.atualiza) begin
      pend = 1'b1;
    end
    hab = bus.habilita;
    t++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    bus.habilita = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (observed() !== 11'b1111_0_0_0000) begin
      $display("FAIL reset_state: got %b expected %b", observed(), 11'b1111_0_0_0000);
    end else passed++;
    rst_n = 1'b1;
    model_reset();
    total++;
    exp_v = expect_out();
    if (observed() !== exp_v) begin
      $display("FAIL reset_release: got %b expected %b", observed(), exp_v);
    end else passed++;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      tick();
      total++;
      exp_v = expect_out();
      if (observed() !== exp_v) begin
        $display("FAIL scan t=%0d: got %b expected %b", t, observed(), exp_v);
      end else passed++;
    end
  endtask

  task automatic test_commit();
    logic [3:0] vals [4];
    vals[0] = 4'h1; vals[1] = 4'h5; vals[2] = 4'h0; vals[3] = 4'h9;
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      if (i < 4) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'(3 - i);
        bus.wr_data = vals[3 - i];
      end else if (i == 9) begin
        bus.atualiza = 1'b1;
      end
      tick();
      total++;
      exp_v = expect_out();
      if (observed() !== exp_v) begin
        $display("FAIL commit t=%0d: got %b expected %b", t, observed(), exp_v);
      end else passed++;
    end
  endtask

  task automatic test_no_commit();
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      if (i == 0) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 4'hF;
      end
      tick();
      total++;
      exp_v = expect_out();
      if (observed() !== exp_v) begin
        $display("FAIL no_commit t=%0d: got %b expected %b", t, observed(), exp_v);
      end else passed++;
    end
  endtask

  task automatic test_boundary_commit();
    int guard;
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0: pendente already set at the boundary; pass 1: set exactly at it
      idle();
      if (pass == 0) bus.atualiza = 1'b1;
      tick();
      idle();
      guard = 0;
      while (((t % FRAME) != FRAME - 1) && (guard < FRAME + 2)) begin
        tick();
        guard++;
      end
      if (guard >= FRAME + 2) begin
        total++;
        $display("FAIL boundary_wait: got %0d cycles expected < %0d", guard, FRAME + 2);
      end
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 2'd2;
      bus.wr_data  = 4'h7;
      bus.atualiza = 1'b1;
      for (int i = 0; i < FRAME + 4; i++) begin
        tick();
        idle();
        total++;
        exp_v = expect_out();
        if (observed() !== exp_v) begin
          $display("FAIL boundary_commit p%0d t=%0d: got %b expected %b", pass, t, observed(), exp_v);
        end else passed++;
      end
    end
  endtask

  task automatic test_habilita();
    int guard;
    idle();
    bus.habilita = 1'b1;
    guard = 0;
    while (((t % FRAME) != DIGIT + BLANK) && (guard < FRAME + 2)) begin
      tick();
      guard++;
    end
    bus.habilita = 1'b0;
    tick();
    total++;
    if (bus.anodo !== 4'b1111) begin
      $display("FAIL habilita_off: got %b expected %b", bus.anodo, 4'b1111);
    end else passed++;
    for (int i = 0; i < 3 * FRAME; i++) begin
      bus.habilita = 1'($urandom_range(0, 1));
      tick();
      total++;
      exp_v = expect_out();
      if (observed() !== exp_v) begin
        $display("FAIL habilita t=%0d: got %b expected %b", t, observed(), exp_v);
      end else passed++;
    end
    bus.habilita = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = 2'($urandom_range(0, 3));
      bus.wr_data  = 4'($urandom_range(0, 15));
      bus.atualiza = ($urandom_range(0, 7) == 0);
      bus.habilita = ($urandom_range(0, 5) != 0);
      tick();
      total++;
      exp_v = expect_out();
      if (observed() !== exp_v) begin
        $display("FAIL random t=%0d: got %b expected %b", t, observed(), exp_v);
      end else passed++;
    end
    idle();
    bus.habilita = 1'b1;
  endtask

  task automatic test_leading_zero();
    logic [15:0] pats [2];
    logic [15:0] pat;
    pats[0] = 16'h0030;
    pats[1] = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      pat = pats[k];
      for (int i = 0; i < 2 * FRAME + 6; i++) begin
        idle();
        if (i < 4) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = 2'(i);
          bus.wr_data = pat[i*4 +: 4];
        end else if (i == 4) begin
          bus.atualiza = 1'b1;
        end
        tick();
        total++;
        exp_v = expect_out();
        if (observed() !== exp_v) begin
          $display("FAIL leading_zero k%0d t=%0d: got %b expected %b", k, t, observed(), exp_v);
        end else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    idle();
    bus.atualiza = 1'b1;
    tick();
    idle();
    guard = 0;
    while (((t % FRAME) != DIGIT + BLANK + 1) && (guard < FRAME + 2)) begin
      tick();
      guard++;
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.anodo, bus.pendente, bus.quadro, bus.A, bus.B, bus.C, bus.D} !== 11'b1111_0_0_0000) begin
      $display("FAIL reset_mid_async: got %b expected %b",
               {bus.anodo, bus.pendente, bus.quadro, bus.A, bus.B, bus.C, bus.D}, 11'b1111_0_0_0000);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME + 6; i++) begin
      tick();
      total++;
      exp_v = expect_out();
      if (observed() !== exp_v) begin
        $display("FAIL reset_mid_after t=%0d: got %b expected %b", t, observed(), exp_v);
      end else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_commit();
    test_no_commit();
    test_boundary_commit();
    test_habilita();
    test_leading_zero();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles each digit is driven (SHOW phase), legal range 1..65535.
REQ-002 SHALL have parameter BLANK, default 4: clock cycles all anodes are off before each digit (BLANK phase), legal range 1..255.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write strobe into shadow digit register.
REQ-006 wr_addr  input  2  shadow digit index written (0 = rightmost).
REQ-007 wr_data  input  4  nibble written.
REQ-008 atualiza  input  1  commit request; shadow-to-active copy at next frame boundary.
REQ-009 habilita  input  1  display enable; low forces all anodes off.
REQ-010 A, B, C, D  output  1 each  registered nibble of current digit to the 7-segment decoder, A = MSB.
REQ-011 anodo  output  4  digit select, one-hot active-low, bit n = digit n.
REQ-012 pendente  output  1  commit requested but not yet applied.
REQ-013 quadro  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL hold two 4x4-bit banks: shadow (written) and active (displayed).
REQ-015 wr_en high SHALL write wr_data into shadow[wr_addr] at that edge; active bank unaffected.
REQ-016 FSM states: BLANK, SHOW; 2-bit digit index idx; cycle counter cnt.
REQ-017 BLANK: anodo = 4'b1111 for exactly BLANK cycles, then SHOW with the same idx.
REQ-018 SHOW: anodo = ~(1 << idx) when habilita = 1, else 4'b1111, for exactly DIV cycles; then BLANK with idx+1 mod 4.
REQ-019 {A,B,C,D} SHALL equal active[idx] throughout BLANK and SHOW of that idx, stable for the whole digit period.
REQ-020 Frame boundary = the cycle leaving SHOW with idx = 3; quadro high exactly that cycle.
REQ-021 atualiza high SHALL set pendente on the next edge; further atualiza while pendente = 1 have no additional effect.
REQ-022 At a frame boundary with pendente = 1: active <- shadow (including any write in the same cycle) and pendente cleared; first digit of the new frame shows the new values.
REQ-023 atualiza coincident with a frame boundary while pendente = 0: pendente set, copy deferred to the following boundary.
REQ-024 habilita changes SHALL take effect on anodo the next cycle; FSM, cnt and idx keep running regardless of habilita.
REQ-025 Frame period SHALL be exactly 4*(BLANK+DIV) cycles; no outputs other than quadro and pendente change at a boundary except as stated.

Reset
REQ-026 rst_n low SHALL immediately force: state BLANK, idx 0, cnt 0, both banks 0, A-D 0, anodo 4'b1111, pendente 0, quadro 0.
REQ-027 After rst_n rises, the first SHOW of digit 0 SHALL begin BLANK cycles later; reset mid-frame discards any pending commit.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN: when defined, during SHOW of digit n (n = 1..3) anodo SHALL stay 4'b1111 if active[n] and all active[m] for m > n are 0; digit 0 is never suppressed.
REQ-029 Without LEADING_ZERO_BLANK_EN every digit is driven per REQ-018 regardless of value.

Verification (DIV = 4, BLANK = 2)
REQ-030 Reset release, habilita = 1 -> anodo 1111 for 2 cycles, 1110 for 4, 1111 for 2, 1101 for 4, ...; quadro pulses every 24 cycles.
REQ-031 Write shadow = {3:4'h9, 2:4'h0, 1:4'h5, 0:4'h1}, pulse atualiza mid-frame -> pendente = 1 until next quadro; next frame {A,B,C,D} = 1,5,0,9 per idx 0..3.
REQ-032 Write shadow[0] = 4'hF without atualiza -> {A,B,C,D} for idx 0 unchanged across 3 frames.
REQ-033 atualiza and wr_en (addr 2, data 4'h7) in the quadro cycle with pendente = 1 -> next frame idx 2 shows 7, pendente clears that cycle.
REQ-034 habilita low during SHOW of idx 1 -> anodo 1111 next cycle, idx sequence and quadro timing unchanged; rst_n low mid-SHOW -> anodo 1111 asynchronously, pendente 0.
REQ-035 LEADING_ZERO_BLANK_EN defined, active = {0,0,3,0} -> anodo low only for digits 0 and 1; active = {0,0,0,0} -> only digit 0 lit.
